demux_4ch_deser: RTL and testbench
==================================

# demux_4ch_deser

Sequential 1-to-4 demultiplexing deserializer for the barrel-shifter lab datapath. A single serial bit stream is steered by a 2-bit select (`sel1`, `sel0`) into one of four independent per-channel shift registers. Each channel assembles a `WIDTH`-bit word and presents it in a holding register with a valid/ack handshake. It is the distribution end of the 4:1 select path: one source in, four destinations out.

## Interface

Parameters:
- `WIDTH`, default 8: word width per channel, legal range 2..32.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `datain`, input, 1: serial data bit.
- `in_valid`, input, 1: `datain` is accepted this cycle.
- `sel0`, input, 1: channel select, LSB.
- `sel1`, input, 1: channel select, MSB; channel index = {`sel1`,`sel0`}.
- `dataout0`..`dataout3`, output, `WIDTH` each: per-channel holding registers.
- `out_valid`, output, 4: bit N high means `dataoutN` holds an unconsumed word.
- `out_ack`, input, 4: bit N consumes channel N's word; ignored when `out_valid[N]` is low.
- `overflow`, output, 4: sticky; bit N is set when a channel-N word is dropped.

## Operation

- Per channel: shift register `sr[N]` (`WIDTH` bits), bit counter `cnt[N]` (0..`WIDTH`-1), holding register `dataoutN`, and flags `out_valid[N]` and `overflow[N]`.
- Idle cycle (`in_valid`=0): no channel shift state changes; ack processing still occurs.
- Accepted bit (`in_valid`=1), selected channel S only:
  - Shift MSB-first: `sr[S] <= {sr[S][WIDTH-2:0], datain}`.
  - If `cnt[S]` < `WIDTH`-1, increment `cnt[S]`.
  - If `cnt[S]` == `WIDTH`-1, the word completes:
    - `cnt[S]` wraps to 0.
    - Completed word W = {`sr[S][WIDTH-2:0]`, `datain`}.
    - Holding free (`out_valid[S]`=0), or `out_ack[S]`=1 in the same cycle: `dataoutS` <= W and `out_valid[S]` <= 1.
    - Otherwise: W is dropped, `dataoutS` is unchanged, and `overflow[S]` <= 1.
- Unselected channels keep their partial `sr` and `cnt`. Switching select mid-word suspends that word; a later return resumes it.
- Ack: `out_ack[N]`=1 with `out_valid[N]`=1 and no completion on N in the same cycle gives `out_valid[N]` <= 0. `dataoutN` keeps its last value.
- `overflow[N]` is cleared only by reset.
- Acks on several channels in one cycle are processed independently.

## Timing

- Reset (async assert, sync release) clears:
  - all `sr`: 0
  - all `cnt`: 0
  - `dataout0`..`dataout3`: 0
  - `out_valid`: 4'b0000
  - `overflow`: 4'b0000
- Reset mid-word discards all partial words.
- Latency: the word is visible on `dataoutS` with `out_valid[S]`=1 in the cycle after the edge that accepts bit `WIDTH`-1.
- Minimum word time: `WIDTH` accepted cycles.
- Back-to-back words on one channel need an ack at or before the completing edge to avoid overflow.
- `sel0`/`sel1` are sampled only when `in_valid`=1; they may change every cycle.
- The ack-to-clear latency is 1 cycle.

## Configuration

- Macro `DEMUX_LSB_FIRST_EN`.
- Defined: each channel shifts LSB-first, `sr <= {datain, sr[WIDTH-1:1]}`, and the completed word is {`datain`, `sr[WIDTH-1:1]`}. The first received bit lands in bit 0.
- Undefined (default): MSB-first as described under Operation. The first received bit lands in bit `WIDTH`-1.
- Counter, handshake and overflow behaviour are identical in both builds.

## Test plan

- Reset check: `WIDTH`=8, assert `rst_n`=0 mid-run → all outputs 0 immediately; after release, an 8-bit send on channel 0 completes correctly with no stale bits.
- Single word: select 2'b10, send bits 1,0,1,0,0,1,0,1 on consecutive cycles → `dataout2`=8'hA5 and `out_valid`=4'b0100 one cycle after the 8th bit; other channels unchanged. With `DEMUX_LSB_FIRST_EN` the same bits give 8'hA5 as well (a palindrome); additionally send 1,0,0,0,0,0,0,0 → 8'h01 (LSB-first build) versus 8'h80 (default build).
- Interleave: 4 bits of 8'hF0 on channel 1, then the full 8'h3C on channel 3, then the remaining 4 bits on channel 1 → `dataout3`=8'h3C first, then `dataout1`=8'hF0.
- Overflow: complete 8'h11 then 8'h22 on channel 0 without ack → `dataout0`=8'h11, `overflow`=4'b0001, `out_valid[0]`=1. Ack, then send 8'h33 → `dataout0`=8'h33 and `overflow[0]` stays 1.
- Simultaneous ack and completion: channel 1 holds 8'h55; pulse `out_ack[1]` on the edge accepting the last bit of 8'hAA → `dataout1`=8'hAA, `out_valid[1]` stays 1, `overflow[1]`=0.
- Idle gaps: 8'hC3 sent with `in_valid` low on random cycles → same result as a contiguous send; `cnt` does not advance on idle cycles.

Source files
------------

// File: rtl/demux_4ch_deser.sv
// 1-to-4 demultiplexing deserializer: serial bits steered by {sel1,sel0} into per-channel
// WIDTH-bit words with valid/ack holding registers. Define DEMUX_LSB_FIRST_EN for LSB-first assembly.
module demux_4ch_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             datain,
    input  logic             in_valid,
    input  logic             sel0,
    input  logic             sel1,
    output logic [WIDTH-1:0] dataout0,
    output logic [WIDTH-1:0] dataout1,
    output logic [WIDTH-1:0] dataout2,
    output logic [WIDTH-1:0] dataout3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic [3:0]       overflow
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q   [4];
    logic [WIDTH-1:0] sr_d   [4];
    logic [CW-1:0]    cnt_q  [4];
    logic [CW-1:0]    cnt_d  [4];
    logic [WIDTH-1:0] dout_q [4];
    logic [WIDTH-1:0] dout_d [4];
    logic [WIDTH-1:0] word_w [4];
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       ovf_q, ovf_d;
    logic [1:0]       sel_w;

    assign sel_w = {sel1, sel0};

    // Shifted value of each channel if it accepts datain this cycle.
    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
`ifdef DEMUX_LSB_FIRST_EN
            word_w[n] = {datain, sr_q[n][WIDTH-1:1]};
`else
            word_w[n] = {sr_q[n][WIDTH-2:0], datain};
`endif
        end
    end

    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        for (int unsigned n = 0; n < 4; n++) begin
            sr_d[n]   = sr_q[n];
            cnt_d[n]  = cnt_q[n];
            dout_d[n] = dout_q[n];
            if (out_ack[n] && valid_q[n]) begin
                valid_d[n] = 1'b0;
            end
            // A completion in the same cycle takes priority over the ack clear.
            if (in_valid && (sel_w == 2'(n))) begin
                sr_d[n] = word_w[n];
                if (cnt_q[n] == CNT_LAST) begin
                    cnt_d[n] = '0;
                    if (!valid_q[n] || out_ack[n]) begin
                        dout_d[n]  = word_w[n];
                        valid_d[n] = 1'b1;
                    end else begin
                        ovf_d[n] = 1'b1;
                    end
                end else begin
                    cnt_d[n] = cnt_q[n] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < 4; n++) begin
                sr_q[n]   <= '0;
                cnt_q[n]  <= '0;
                dout_q[n] <= '0;
            end
            valid_q <= '0;
            ovf_q   <= '0;
        end else begin
            for (int unsigned n = 0; n < 4; n++) begin
                sr_q[n]   <= sr_d[n];
                cnt_q[n]  <= cnt_d[n];
                dout_q[n] <= dout_d[n];
            end
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dataout0  = dout_q[0];
    assign dataout1  = dout_q[1];
    assign dataout2  = dout_q[2];
    assign dataout3  = dout_q[3];
    assign out_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_demux_4ch_deser.sv
// Directed self-checking bench for demux_4ch_deser at WIDTH=8; expectations follow
// DEMUX_LSB_FIRST_EN when the bench is compiled with the same macro as the design.
module tb_demux_4ch_deser;

    logic       clk;
    logic       rst_n;
    logic       datain;
    logic       in_valid;
    logic       sel0;
    logic       sel1;
    logic [7:0] dataout0, dataout1, dataout2, dataout3;
    logic [3:0] out_valid;
    logic [3:0] out_ack;
    logic [3:0] overflow;

    int checks = 0;
    int errors = 0;

    demux_4ch_deser #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .datain    (datain),
        .in_valid  (in_valid),
        .sel0      (sel0),
        .sel1      (sel1),
        .dataout0  (dataout0),
        .dataout1  (dataout1),
        .dataout2  (dataout2),
        .dataout3  (dataout3),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit k of the stream that assembles val in this build.
    function automatic logic bit_of(input logic [7:0] val, input int k);
`ifdef DEMUX_LSB_FIRST_EN
        return val[k];
`else
        return val[7-k];
`endif
    endfunction

    task automatic send_bit(input int ch, input logic b, input logic ack_it);
        @(negedge clk);
        in_valid = 1'b1;
        {sel1, sel0} = 2'(ch);
        datain = b;
        if (ack_it) out_ack[ch] = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        datain = 1'b0;
        out_ack = 4'b0000;
    endtask

    task automatic send_bits(input int ch, input logic [7:0] val, input int k0, input int k1,
                             input logic ack_last);
        for (int k = k0; k <= k1; k++) send_bit(ch, bit_of(val, k), ack_last && (k == 7));
    endtask

    task automatic ack(input logic [3:0] mask);
        @(negedge clk);
        out_ack = mask;
        @(posedge clk);
        #1;
        out_ack = 4'b0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    logic [7:0] raw;
    logic [7:0] exp_raw;

    initial begin
        rst_n = 1'b0; datain = 1'b0; in_valid = 1'b0; sel0 = 1'b0; sel1 = 1'b0; out_ack = 4'b0000;
        #12;
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_ovf", 32'(overflow), 32'h0);
        chk("reset_d0", 32'(dataout0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Single word on channel 2 from raw bits (palindrome: A5 in both builds)
        raw = 8'b10100101;
        for (int k = 0; k < 7; k++) send_bit(2, raw[7-k], 1'b0);
        chk("single_pre_valid", 32'(out_valid), 32'h0);
        send_bit(2, raw[0], 1'b0);
        chk("single_d2", 32'(dataout2), 32'hA5);
        chk("single_valid", 32'(out_valid), 32'h4);
        chk("single_d0", 32'(dataout0), 32'h0);
        chk("single_d3", 32'(dataout3), 32'h0);

        // Bit order: 1 then seven 0s on channel 3
        send_bit(3, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) send_bit(3, 1'b0, 1'b0);
`ifdef DEMUX_LSB_FIRST_EN
        exp_raw = 8'h01;
`else
        exp_raw = 8'h80;
`endif
        chk("order_d3", 32'(dataout3), 32'(exp_raw));
        chk("order_valid", 32'(out_valid), 32'hC);
        ack(4'b1100);
        chk("ack_multi_valid", 32'(out_valid), 32'h0);
        chk("ack_keep_d2", 32'(dataout2), 32'hA5);
        ack(4'b0001);
        chk("ack_ignored", 32'(out_valid | overflow), 32'h0);

        // Interleave: half of F0 on ch1, full 3C on ch3, rest of F0 on ch1
        send_bits(1, 8'hF0, 0, 3, 1'b0);
        send_bits(3, 8'h3C, 0, 7, 1'b0);
        chk("ilv_d3", 32'(dataout3), 32'h3C);
        chk("ilv_valid_a", 32'(out_valid), 32'h8);
        send_bits(1, 8'hF0, 4, 7, 1'b0);
        chk("ilv_d1", 32'(dataout1), 32'hF0);
        chk("ilv_valid_b", 32'(out_valid), 32'hA);
        ack(4'b1010);

        // Overflow on channel 0
        send_bits(0, 8'h11, 0, 7, 1'b0);
        send_bits(0, 8'h22, 0, 7, 1'b0);
        chk("ovf_d0", 32'(dataout0), 32'h11);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_valid", 32'(out_valid), 32'h1);
        ack(4'b0001);
        chk("ovf_ack_valid", 32'(out_valid), 32'h0);
        send_bits(0, 8'h33, 0, 7, 1'b0);
        chk("ovf_d0_33", 32'(dataout0), 32'h33);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        ack(4'b0001);

        // Ack coinciding with completion on channel 1
        send_bits(1, 8'h55, 0, 7, 1'b0);
        chk("sim_d1_55", 32'(dataout1), 32'h55);
        send_bits(1, 8'hAA, 0, 7, 1'b1);
        chk("sim_d1_aa", 32'(dataout1), 32'hAA);
        chk("sim_valid", 32'(out_valid), 32'h2);
        chk("sim_ovf", 32'(overflow), 32'h1);
        ack(4'b0010);

        // Idle gaps inside a word on channel 2
        for (int k = 0; k < 7; k++) begin
            send_bit(2, bit_of(8'hC3, k), 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
        chk("gap_pre_valid", 32'(out_valid), 32'h0);
        send_bit(2, bit_of(8'hC3, 7), 1'b0);
        chk("gap_d2", 32'(dataout2), 32'hC3);
        chk("gap_valid", 32'(out_valid), 32'h4);

        // Reset mid-word discards partial state
        send_bits(0, 8'hFF, 0, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_ovf", 32'(overflow), 32'h0);
        chk("mid_rst_d2", 32'(dataout2), 32'h0);
        chk("mid_rst_d1", 32'(dataout1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(0, 8'h96, 0, 7, 1'b0);
        chk("post_rst_d0", 32'(dataout0), 32'h96);
        chk("post_rst_valid", 32'(out_valid), 32'h1);
        chk("post_rst_ovf", 32'(overflow), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
